// File: rtl/bios_wd_pkg.sv
// BIOS watchdog shared types.
// FSM state encoding and LPC command field values.
package bios_wd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    EXPIRED = 2'd2,
    DONE    = 2'd3
  } wd_state_t;

  localparam logic [1:0] CMD_DISABLE   = 2'b00;
  localparam logic [1:0] CMD_ARM       = 2'b01;
  localparam logic [1:0] CMD_KICK      = 2'b10;
  localparam logic [1:0] CMD_POST_DONE = 2'b11;

endpackage

// File: rtl/bios_watchdog_prescaler.sv
// Watchdog tick prescaler.
// Counts clocks while enabled; held at zero otherwise.
module wd_prescaler #(
  parameter int CLK_PER_TICK = 33_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int W = $clog2(CLK_PER_TICK);
  localparam logic [W-1:0] LAST = W'(CLK_PER_TICK - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  // Next count: wrap on tick, zero when cleared or disabled.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || !en_i || tick_o) begin
      cnt_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bios_watchdog.sv
// BIOS boot watchdog.
// Command decode, countdown FSM, failure count and swap request.
module bios_watchdog
  import bios_wd_pkg::*;
#(
  parameter int         CLK_PER_TICK    = 33_000_000,
  parameter bit         AUTO_ARM        = 1'b1,
  parameter logic [5:0] DEFAULT_TIMEOUT = 6'd60,
  parameter logic [1:0] SWAP_AFTER      = 2'd2
) (
  input  logic       LpcClock,
  input  logic       PciReset,
  input  logic       WriteBiosWD,
  input  logic [7:0] BiosRegister,
  output logic [1:0] WdState,
  output logic [5:0] WdRemain,
  output logic       WdTimeout,
  output logic [1:0] FailCount,
  output logic       BiosSwapReq,
  output logic       BiosOk
);

  wd_state_t  state_q, state_d;
  logic [5:0] remain_q, remain_d;
  logic [5:0] reload_q, reload_d;
  logic [1:0] fail_q, fail_d;
  logic       swap_q, swap_d;
  logic       to_q, to_d;
  logic       ok_q;
  logic       cmd_v_q;
  logic       tick;

  logic [1:0] cmd;
  logic [5:0] op;
  logic       armed;
  logic       do_dis, do_arm, do_kick, do_post, do_tick;

  assign cmd   = BiosRegister[7:6];
  assign op    = BiosRegister[5:0];
  assign armed = (state_q == ARMED);

  assign do_dis  = cmd_v_q && ((cmd == CMD_DISABLE) ||
                   ((cmd == CMD_ARM) && (op == 6'd0)));
  assign do_arm  = cmd_v_q && (cmd == CMD_ARM) && (op != 6'd0);
  assign do_kick = cmd_v_q && (cmd == CMD_KICK) && armed;
  assign do_post = cmd_v_q && (cmd == CMD_POST_DONE) && armed;
  assign do_tick = tick && !cmd_v_q;

  // Any command cycle restarts the tick phase; a coincident tick is lost.
  wd_prescaler #(
    .CLK_PER_TICK(CLK_PER_TICK)
  ) u_pre (
    .clk_i (LpcClock),
    .rst_i (PciReset),
    .en_i  (armed),
    .clr_i (cmd_v_q),
    .tick_o(tick)
  );

  // Next-state: commands take priority over the countdown.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    reload_d = reload_q;
    fail_d   = fail_q;
    swap_d   = swap_q;
    to_d     = 1'b0;
    unique case (1'b1)
      do_dis: begin
        state_d  = IDLE;
        remain_d = 6'd0;
      end
      do_arm: begin
        state_d  = ARMED;
        remain_d = op;
        reload_d = op;
      end
      do_kick: begin
        remain_d = reload_q;
      end
      do_post: begin
        state_d = DONE;
      end
      do_tick: begin
        if (remain_q > 6'd1) begin
          remain_d = remain_q - 6'd1;
        end else begin
          remain_d = 6'd0;
          state_d  = EXPIRED;
          to_d     = 1'b1;
          fail_d   = (fail_q == 2'd3) ? 2'd3 : fail_q + 2'd1;
          swap_d   = swap_q || (fail_d >= SWAP_AFTER);
        end
      end
      default: begin
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge LpcClock) begin
    if (PciReset) begin
      cmd_v_q  <= 1'b0;
      reload_q <= DEFAULT_TIMEOUT;
      fail_q   <= 2'd0;
      swap_q   <= 1'b0;
      to_q     <= 1'b0;
      ok_q     <= 1'b0;
      if (AUTO_ARM) begin
        state_q  <= ARMED;
        remain_q <= DEFAULT_TIMEOUT;
      end else begin
        state_q  <= IDLE;
        remain_q <= 6'd0;
      end
    end else begin
      cmd_v_q  <= WriteBiosWD;
      state_q  <= state_d;
      remain_q <= remain_d;
      reload_q <= reload_d;
      fail_q   <= fail_d;
      swap_q   <= swap_d;
      to_q     <= to_d;
      ok_q     <= (state_d == DONE);
    end
  end

  assign WdState     = state_q;
  assign WdRemain    = remain_q;
  assign WdTimeout   = to_q;
  assign FailCount   = fail_q;
  assign BiosSwapReq = swap_q;
  assign BiosOk      = ok_q;

endmodule

// File: tb/tb_bios_watchdog.sv
// BIOS watchdog bench: two configs vs a deadline-based model.
// Directed scenarios followed by random commands and resets.
module tb_bios_watchdog;

  localparam int CPT = 4;
  localparam int SWP = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stb = 1'b0;
  logic [7:0] breg = 8'h00;

  logic [1:0] st0, st1, fl0, fl1;
  logic [5:0] rm0, rm1;
  logic       to0, to1, sw0, sw1, ok0, ok1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bios_watchdog #(
    .CLK_PER_TICK(CPT), .AUTO_ARM(1'b0),
    .DEFAULT_TIMEOUT(6'd60), .SWAP_AFTER(2'd2)
  ) dut0 (
    .LpcClock(clk), .PciReset(rst),
    .WriteBiosWD(stb), .BiosRegister(breg),
    .WdState(st0), .WdRemain(rm0), .WdTimeout(to0),
    .FailCount(fl0), .BiosSwapReq(sw0), .BiosOk(ok0)
  );

  bios_watchdog #(
    .CLK_PER_TICK(CPT), .AUTO_ARM(1'b1),
    .DEFAULT_TIMEOUT(6'd2), .SWAP_AFTER(2'd2)
  ) dut1 (
    .LpcClock(clk), .PciReset(rst),
    .WriteBiosWD(stb), .BiosRegister(breg),
    .WdState(st1), .WdRemain(rm1), .WdTimeout(to1),
    .FailCount(fl1), .BiosSwapReq(sw1), .BiosOk(ok1)
  );

  // Model: remaining ticks derived from restart edge and elapsed edges.
  typedef struct {
    bit   valid;
    int   e;
    int   start;
    int   t0;
    int   rem;
    int   reload;
    int   st;
    int   fail;
    bit   swap;
    bit   to;
    bit   ok;
    bit   pend;
  } model_t;

  model_t m0, m1;

  function automatic model_t mstep(model_t m, bit r, bit s,
                                   logic [7:0] v, bit auto_arm,
                                   int dflt);
    model_t n;
    int c, o;
    n = m;
    n.e = m.e + 1;
    n.to = 1'b0;
    c = int'(v[7:6]);
    o = int'(v[5:0]);
    if (r) begin
      n.valid  = 1'b1;
      n.st     = auto_arm ? 1 : 0;
      n.rem    = auto_arm ? dflt : 0;
      n.t0     = dflt;
      n.start  = n.e;
      n.reload = dflt;
      n.fail   = 0;
      n.swap   = 1'b0;
      n.pend   = 1'b0;
      n.ok     = 1'b0;
      return n;
    end
    if (m.pend) begin
      if (c == 0 || (c == 1 && o == 0)) begin
        n.st = 0; n.rem = 0;
      end else if (c == 1) begin
        n.st = 1; n.reload = o; n.t0 = o;
        n.start = n.e; n.rem = o;
      end else if (c == 2 && m.st == 1) begin
        n.t0 = m.reload; n.start = n.e; n.rem = m.reload;
      end else if (c == 3 && m.st == 1) begin
        n.st = 3;
      end
    end else if (m.st == 1) begin
      n.rem = m.t0 - (n.e - m.start) / CPT;
      if (n.rem <= 0) begin
        n.rem  = 0;
        n.st   = 2;
        n.to   = 1'b1;
        n.fail = (m.fail == 3) ? 3 : m.fail + 1;
        if (n.fail >= SWP) n.swap = 1'b1;
      end
    end
    n.pend = s;
    n.ok = (n.st == 3);
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: compare at negedge, drive, then advance the model.
  task automatic cyc(input bit s, input logic [7:0] v, input bit r);
    @(negedge clk);
    if (m0.valid) begin
      chk("st0", 32'(st0), 32'(m0.st));
      chk("rm0", 32'(rm0), 32'(m0.rem));
      chk("to0", 32'(to0), 32'(m0.to));
      chk("fl0", 32'(fl0), 32'(m0.fail));
      chk("sw0", 32'(sw0), 32'(m0.swap));
      chk("ok0", 32'(ok0), 32'(m0.ok));
      chk("st1", 32'(st1), 32'(m1.st));
      chk("rm1", 32'(rm1), 32'(m1.rem));
      chk("to1", 32'(to1), 32'(m1.to));
      chk("fl1", 32'(fl1), 32'(m1.fail));
      chk("sw1", 32'(sw1), 32'(m1.swap));
      chk("ok1", 32'(ok1), 32'(m1.ok));
    end
    stb = s;
    rst = r;
    if (s) breg = v;
    @(posedge clk);
    m0 = mstep(m0, r, s, breg, 1'b0, 60);
    m1 = mstep(m1, r, s, breg, 1'b1, 2);
  endtask

  task automatic wr(input logic [7:0] v);
    cyc(1'b1, v, 1'b0);
    cyc(1'b0, v, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, breg, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b0, breg, 1'b1);
    cyc(1'b0, breg, 1'b1);
  endtask

  int hit;
  bit prev_s;

  initial begin
    m0 = '{default: 0};
    m1 = '{default: 0};
    do_reset();

    // Scenario 1: ARM T=3, expiry 12 cycles after ARM takes effect.
    wr(8'h43);
    hit = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, breg, 1'b0);
      #1;
      if (to0 && hit == 0) hit = i + 1;
    end
    chk("s1_lat", 32'(hit), 32'd12);
    chk("s1_st", 32'(st0), 32'd2);
    chk("s1_fail", 32'(fl0), 32'd1);
    chk("s1_swap", 32'(sw0), 32'd0);

    // Scenario 2: KICK mid-countdown.
    wr(8'h43);
    idle(4);
    wr(8'h80);
    idle(20);

    // Scenario 3: two expiries raise the swap request.
    do_reset();
    wr(8'h42);
    idle(10);
    wr(8'h42);
    idle(10);
    wr(8'h00);
    idle(2);
    #1;
    chk("s3_fail", 32'(fl0), 32'd2);
    chk("s3_swap", 32'(sw0), 32'd1);
    chk("s3_st", 32'(st0), 32'd0);

    // Scenario 4: POST_DONE, ignored KICK, DISABLE.
    wr(8'h45);
    idle(2);
    wr(8'hC0);
    idle(1);
    #1;
    chk("s4_st", 32'(st0), 32'd3);
    chk("s4_ok", 32'(ok0), 32'd1);
    wr(8'h80);
    idle(30);
    #1;
    chk("s4_hold", 32'(st0), 32'd3);
    wr(8'h00);
    idle(1);
    #1;
    chk("s4_idle", 32'(st0), 32'd0);
    chk("s4_okc", 32'(ok0), 32'd0);

    // Scenario 5: KICK decode on the final tick; ARM with T=0.
    wr(8'h42);
    idle(6);
    wr(8'h80);
    #1;
    chk("s5_rem", 32'(rm0), 32'd2);
    chk("s5_st", 32'(st0), 32'd1);
    idle(3);
    wr(8'h40);
    idle(1);
    #1;
    chk("s5_arm0", 32'(st0), 32'd0);

    // Scenario 6: auto-arm expiry and mid-countdown reset.
    do_reset();
    idle(10);
    do_reset();
    idle(4);
    cyc(1'b0, breg, 1'b1);
    #1;
    chk("s6_rem", 32'(rm1), 32'd2);
    chk("s6_st", 32'(st1), 32'd1);
    chk("s6_fail", 32'(fl1), 32'd0);
    idle(12);

    // Random commands, idle gaps and occasional resets.
    prev_s = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] v;
      bit s, r;
      r = ($urandom_range(0, 199) == 0);
      s = !prev_s && !r && ($urandom_range(0, 5) == 0);
      v = breg;
      if (s) begin
        v[7:6] = 2'($urandom_range(0, 3));
        v[5:0] = ($urandom_range(0, 7) == 0) ?
                 6'd0 : 6'($urandom_range(1, 6));
      end
      cyc(s, v, r);
      prev_s = s;
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bios_watchdog.md
# bios_watchdog

BIOS boot watchdog, directly downstream of the LPC register block. It consumes the BIOS-watchdog write strobe and the BIOS watchdog register. It runs a seconds-based countdown while the BIOS posts. On expiry it reports a timeout, counts failures, and requests a BIOS flash swap after repeated failures. It runs in the LPC clock domain, and its status outputs feed the power sequencer and the LPC read mux.

## Interface

Parameters:
- CLK_PER_TICK, 33_000_000: LpcClock cycles per watchdog tick (1 s at 33 MHz); must be ≥ 2.
- AUTO_ARM, 1: arm automatically after reset.
- DEFAULT_TIMEOUT, 6'd60: tick count loaded on auto-arm; must be non-zero.
- SWAP_AFTER, 2'd2: failure count at which BiosSwapReq asserts; must be non-zero.

Ports:
- LpcClock, in, 1: 33 MHz LPC clock, the only clock.
- PciReset, in, 1: reset, synchronous, active-high.
- WriteBiosWD, in, 1: one-cycle strobe, asserted on a write to register 0x01.
- BiosRegister, in, 8: BIOS watchdog register. It holds the new value one cycle after WriteBiosWD.
- WdState, out, 2: current FSM state, encoded IDLE=0, ARMED=1, EXPIRED=2, DONE=3.
- WdRemain, out, 6: ticks remaining before expiry.
- WdTimeout, out, 1: one-cycle pulse on expiry.
- FailCount, out, 2: saturating count of expiries.
- BiosSwapReq, out, 1: level output; requests a swap to the alternate BIOS.
- BiosOk, out, 1: level output; the BIOS has reported POST complete.

## Operation

- The block registers WriteBiosWD into cmd_v. It decodes BiosRegister in the cycle cmd_v=1, which is one cycle after the strobe.
- Command field is BiosRegister[7:6]. Operand field is BiosRegister[5:0].
  - 00 DISABLE: go to IDLE; WdRemain=0. FailCount and BiosSwapReq are unchanged.
  - 01 ARM: operand=0 acts as DISABLE. Otherwise store operand in reload_r, set WdRemain=operand, clear the prescaler, go to ARMED. Accepted in any state, including re-arm from EXPIRED.
  - 10 KICK: only in ARMED. Set WdRemain=reload_r and clear the prescaler. Ignored in other states.
  - 11 POST_DONE: only in ARMED. Go to DONE and set BiosOk=1. Ignored in other states.
- Prescaler:
  - Counts 0..CLK_PER_TICK-1 only while in ARMED. It is held at 0 in every other state.
  - tick=1 on the cycle the prescaler equals CLK_PER_TICK-1; the prescaler then wraps to 0.
- Countdown:
  - On tick in ARMED with WdRemain>1: decrement WdRemain.
  - On tick with WdRemain==1: WdRemain=0, state goes to EXPIRED, WdTimeout pulses, FailCount increments (saturating at 3).
  - On the same edge, if the new FailCount ≥ SWAP_AFTER, BiosSwapReq goes to 1 and stays set until reset.
- EXPIRED holds until an ARM or DISABLE command.
- DONE is left only by an ARM or DISABLE command. BiosOk clears whenever the block leaves DONE.
- A command cycle and a tick in the same cycle: the command wins, and the tick is discarded (no decrement, no expiry).

## Timing

- Reset values of all outputs:
  - AUTO_ARM=1: WdState=ARMED, WdRemain=DEFAULT_TIMEOUT.
  - AUTO_ARM=0: WdState=IDLE, WdRemain=0.
  - WdTimeout=0, FailCount=0, BiosSwapReq=0, BiosOk=0.
  - Internal: prescaler=0, cmd_v=0, reload_r=DEFAULT_TIMEOUT.
- Reset asserted mid-countdown aborts the countdown. Reset values apply on the next edge, and a pending cmd_v is dropped.
- Command latency: strobe at edge N; new state and WdRemain visible after edge N+2.
- Expiry timing:
  - After an ARM with operand T, WdTimeout is high for exactly one cycle.
  - It rises T·CLK_PER_TICK cycles after the ARM takes effect, with no kicks in between.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure

- Shared package bios_wd_pkg holds:
  - typedef enum logic [1:0] wd_state_t {IDLE, ARMED, EXPIRED, DONE}
  - command constants CMD_DISABLE=2'b00, CMD_ARM=2'b01, CMD_KICK=2'b10, CMD_POST_DONE=2'b11
- One sub-module, wd_prescaler: counter width $clog2(CLK_PER_TICK), with enable and clear inputs and a tick output.
- FSM, countdown, fail counter and command decode live in the top module.

## Test plan

All scenarios use CLK_PER_TICK=4, AUTO_ARM=0, SWAP_AFTER=2.

1. Write 0x43 (ARM, T=3), then no activity → WdState=1, WdRemain steps 3→2→1→0 every 4 cycles. WdTimeout pulses once at cycle 12 after the ARM takes effect. WdState=2, FailCount=1, BiosSwapReq=0.
2. Write 0x43, then write 0x80 (KICK) at cycle 6 → WdRemain reloads to 3 and the prescaler restarts. Expiry moves to 12 cycles after the KICK takes effect.
3. Two ARM/expire sequences (0x42 twice) → FailCount=2. BiosSwapReq rises on the second expiry edge and stays high through a later 0x00 (DISABLE).
4. Write 0x45, then 0xC0 (POST_DONE) → WdState=3, BiosOk=1, no WdTimeout ever. A subsequent 0x80 is ignored. Then 0x00 → IDLE, BiosOk=0.
5. Edge cases:
   - A KICK decode cycle that coincides with the tick where WdRemain==1 → no expiry, WdRemain=reload.
   - 0x40 (ARM, T=0) → IDLE.
6. AUTO_ARM=1, DEFAULT_TIMEOUT=2:
   - Release reset → WdTimeout at cycle 8.
   - Assert reset at cycle 5 → WdRemain returns to 2, WdState=ARMED, FailCount=0.
